demux_1x4_stream: RTL and testbench

Registered 1-to-4 stream demultiplexer with valid/ready handshakes, the distribution counterpart of the team's 4:1 multiplexers. It routes each accepted input beat to one of four output channels, chosen either by an explicit select or by an internal round-robin pointer. Each channel holds one beat in its own register. The block sits between a single producer and four independent consumers in the combinational/datapath library.

---
 rtl/demux_pkg.sv | 12 +
 rtl/demux_1x4_slot.sv | 33 +++
 rtl/demux_1x4_stream.sv | 59 +++++
 tb/tb_demux_1x4_stream.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-4 stream demultiplexer.
package demux_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  // LSB position of channel ch inside a packed NUM_CH*width bus.
  function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/demux_1x4_slot.sv
// One-entry output channel register with full flag and valid/ready drain.
module demux_1x4_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  // Load wins over drain, so a same-cycle replace keeps the slot full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
    end else if (load) begin
      out_data <= load_data;
    end
  end

endmodule

// File: rtl/demux_1x4_stream.sv
// Registered 1-to-4 stream demultiplexer: explicit-select or round-robin routing
// of valid/ready beats into four one-entry channel slots.
module demux_1x4_stream
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rr_en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [SEL_W-1:0]        rr_ptr
);

  logic [SEL_W-1:0]  tgt;
  logic              accept;
  logic [NUM_CH-1:0] load;

  assign tgt      = rr_en ? rr_ptr : in_sel;
  // A full target that drains this cycle can still take the new beat.
  assign in_ready = !out_valid[tgt] || out_ready[tgt];
  assign accept   = in_valid && in_ready;

  always_comb begin
    load = '0;
    if (accept) begin
      load[tgt] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept && rr_en) begin
      rr_ptr <= rr_ptr + 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_1x4_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .load_data (in_data),
      .out_ready (out_ready[k]),
      .out_valid (out_valid[k]),
      .out_data  (out_data[ch_lsb(k, WIDTH) +: WIDTH])
    );
  end

endmodule

// File: tb/tb_demux_1x4_stream.sv
// Scoreboard bench for demux_1x4_stream: per-channel expected queues, directed and random traffic.
module tb_demux_1x4_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rr_en = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic [1:0]  in_sel = '0;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = '0;
  logic [31:0] out_data;
  logic [1:0]  rr_ptr;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: a FIFO of expected beats per channel plus the round-robin target.
  logic [7:0]  exp_q[4][$];
  int unsigned m_ptr = 0;

  demux_1x4_stream #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rr_en     (rr_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .rr_ptr    (rr_ptr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: on the falling edge, compare channel state and retire drained beats.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("rr_ptr", {30'd0, rr_ptr}, m_ptr);
        for (int k = 0; k < 4; k++) begin
          check("out_valid", {31'd0, out_valid[k]}, (exp_q[k].size() != 0) ? 32'd1 : 32'd0);
          if (exp_q[k].size() != 0) begin
            check("out_data", {24'd0, out_data[k*8 +: 8]}, {24'd0, exp_q[k][0]});
            if (out_ready[k]) void'(exp_q[k].pop_front());
          end
        end
      end
    end
  end

  // Drive one cycle of inputs (called at posedge+1), predict acceptance, return at next posedge+1.
  task automatic step(input logic v, input logic [1:0] sel, input logic rr,
                      input logic [3:0] ordy, input logic [7:0] d, output logic acc);
    int unsigned tgt;
    logic        rdy;
    in_valid  = v;
    in_sel    = sel;
    rr_en     = rr;
    out_ready = ordy;
    in_data   = d;
    @(negedge clk);
    #3;
    tgt = rr ? m_ptr : int'(sel);
    // After this cycle's drains are retired, the target is free iff its queue is empty.
    rdy = (exp_q[tgt].size() == 0);
    check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    acc = v && rdy;
    if (acc) begin
      exp_q[tgt].push_back(d);
      if (rr) m_ptr = (m_ptr + 1) % 4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    check("rst_out_valid", {28'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_rr_ptr", {30'd0, rr_ptr}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic       acc;
    logic       pend;
    logic [7:0] hd;
    logic [1:0] hs;
    int unsigned n_acc;

    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state();

    // Explicit select with stalled consumer, then same-cycle replace.
    step(1'b1, 2'd2, 1'b0, 4'b0000, 8'hA1, acc);
    check("a1_accept", {31'd0, acc}, 32'd1);
    check("a1_valid", {28'd0, out_valid}, 32'h4);
    check("a1_data", {24'd0, out_data[23:16]}, 32'hA1);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 2'd2, 1'b0, 4'b0000, 8'hB2, acc);
      check("b2_stall", {31'd0, acc}, 32'd0);
    end
    step(1'b1, 2'd2, 1'b0, 4'b0100, 8'hB2, acc);
    check("b2_accept", {31'd0, acc}, 32'd1);
    check("b2_data", {24'd0, out_data[23:16]}, 32'hB2);
    step(1'b0, 2'd0, 1'b0, 4'b1111, 8'h00, acc);
    check("hold_after_drain", {24'd0, out_data[23:16]}, 32'hB2);

    // Round-robin streaming at full rate.
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'd0, 1'b1, 4'b1111, 8'h10 + 8'(i), acc);
      if (acc) n_acc++;
    end
    check("rr_stream_accepts", n_acc, 32'd8);
    step(1'b0, 2'd0, 1'b1, 4'b1111, 8'h00, acc);

    // Blocked round-robin target holds the pointer.
    step(1'b1, 2'd1, 1'b0, 4'b0000, 8'h51, acc);
    step(1'b1, 2'd0, 1'b1, 4'b0000, 8'h50, acc);
    check("rr_at_1", {30'd0, rr_ptr}, 32'd1);
    step(1'b1, 2'd0, 1'b1, 4'b1101, 8'h52, acc);
    check("blocked_stall", {31'd0, acc}, 32'd0);
    check("blocked_ptr", {30'd0, rr_ptr}, 32'd1);
    step(1'b1, 2'd0, 1'b1, 4'b1111, 8'h52, acc);
    check("release_ptr", {30'd0, rr_ptr}, 32'd2);

    // Mode switch keeps the pointer.
    step(1'b1, 2'd0, 1'b1, 4'b1111, 8'h62, acc);
    check("ptr_3", {30'd0, rr_ptr}, 32'd3);
    step(1'b1, 2'd0, 1'b0, 4'b1111, 8'h70, acc);
    check("sel_mode_ch0", {24'd0, out_data[7:0]}, 32'h70);
    check("sel_mode_ptr", {30'd0, rr_ptr}, 32'd3);
    step(1'b1, 2'd0, 1'b1, 4'b1111, 8'h73, acc);
    check("back_to_rr_ch3", {24'd0, out_data[31:24]}, 32'h73);
    step(1'b0, 2'd0, 1'b1, 4'b1111, 8'h00, acc);

    // Random stress; a pending beat keeps its data and select until taken.
    pend = 1'b0;
    hd = '0;
    hs = '0;
    for (int i = 0; i < 10000; i++) begin
      logic       v;
      logic [3:0] r;
      v = pend || ($urandom_range(0, 3) != 0);
      if (!pend) begin
        hd = 8'($urandom);
        hs = 2'($urandom);
      end
      for (int k = 0; k < 4; k++) r[k] = ($urandom_range(0, 3) != 0);
      step(v, hs, 1'($urandom), r, hd, acc);
      pend = v && !acc;
    end
    step(1'b0, 2'd0, 1'b0, 4'b1111, 8'h00, acc);
    for (int k = 0; k < 4; k++) check("drained", exp_q[k].size(), 32'd0);

    // Asynchronous reset with channel 2 full.
    step(1'b1, 2'd2, 1'b0, 4'b0000, 8'hC2, acc);
    check("pre_reset_valid", {28'd0, out_valid}, 32'h4);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    m_ptr = 0;
    #1;
    check_reset_state();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_state();
    step(1'b1, 2'd3, 1'b1, 4'b0000, 8'hD0, acc);
    check("post_reset_ch0", {24'd0, out_data[7:0]}, 32'hD0);
    step(1'b0, 2'd0, 1'b0, 4'b1111, 8'h00, acc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
